// File: rtl/io_test_sequencer.sv
// Stimulus-and-check harness for a computer's I/O ports: holds the DUT in reset,
// walks a preloaded vector table, checks masked outputs and reports the result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start after reset
// HOLD  | dut_resetn low, dut_in zero, RESET_CYCLES countdown
// APPLY | table[step].in driven, STEP_CYCLES settle countdown
// CHECK | one cycle; dut_out compared against masked expected values
// DONE  | result held until the next start or reset
module io_test_sequencer #(
  parameter int WIDTH        = 32,
  parameter int NUM_IN       = 2,
  parameter int NUM_OUT      = 2,
  parameter int DEPTH        = 16,
  parameter int RESET_CYCLES = 4,
  parameter int STEP_CYCLES  = 8,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ld_we,
  input  logic [AW-1:0]            ld_addr,
  input  logic [NUM_IN*WIDTH-1:0]  ld_in,
  input  logic [NUM_OUT*WIDTH-1:0] ld_exp,
  input  logic [NUM_OUT-1:0]       ld_mask,
  input  logic                     start,
  input  logic [AW:0]              n_steps,
  input  logic [NUM_OUT*WIDTH-1:0] dut_out,
  output logic                     dut_resetn,
  output logic [NUM_IN*WIDTH-1:0]  dut_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_count,
  output logic [AW-1:0]            first_fail
);

  localparam int CMAX = (RESET_CYCLES > STEP_CYCLES) ? RESET_CYCLES : STEP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_TC  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] APPLY_TC = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [NUM_IN*WIDTH-1:0]  tbl_in   [0:DEPTH-1];
  logic [NUM_OUT*WIDTH-1:0] tbl_exp  [0:DEPTH-1];
  logic [NUM_OUT-1:0]       tbl_mask [0:DEPTH-1];

  logic [CW-1:0] cnt;
  logic [AW-1:0] step;
  logic [AW-1:0] step_inc;
  logic [AW:0]   n_lat;
  logic          addr_ok;
  logic          step_fail;
  logic          last_step;
  logic          cnt_tc;

  // A power-of-two table is addressed completely by ld_addr; otherwise trim the top.
  generate
    if (DEPTH == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = ({1'b0, ld_addr} < DEPTH_W);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (ld_we && !busy && addr_ok) begin
      tbl_in[ld_addr]   <= ld_in;
      tbl_exp[ld_addr]  <= ld_exp;
      tbl_mask[ld_addr] <= ld_mask;
    end
  end

  assign step_inc  = step + AW'(1);
  assign cnt_tc    = (cnt == '0);
  assign last_step = ({1'b0, step} == (n_lat - (AW+1)'(1)));

  always_comb begin
    step_fail = 1'b0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (tbl_mask[step][j] &&
          (dut_out[j*WIDTH +: WIDTH] != tbl_exp[step][j*WIDTH +: WIDTH])) begin
        step_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dut_resetn = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_HOLD;
      end
      S_HOLD: begin
        dut_resetn = 1'b0;
        busy       = 1'b1;
        if (cnt_tc) state_next = (n_lat == '0) ? S_DONE : S_APPLY;
      end
      S_APPLY: begin
        busy = 1'b1;
        if (cnt_tc) state_next = S_CHECK;
      end
      S_CHECK: begin
        busy       = 1'b1;
        state_next = last_step ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == 8'd0);
        if (start) state_next = S_HOLD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      step       <= '0;
      n_lat      <= '0;
      err_count  <= 8'd0;
      first_fail <= '0;
      dut_in     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_lat      <= (n_steps > DEPTH_W) ? DEPTH_W : n_steps;
            err_count  <= 8'd0;
            first_fail <= '0;
            dut_in     <= '0;
            step       <= '0;
            cnt        <= HOLD_TC;
          end
        end
        S_HOLD: begin
          if (!cnt_tc) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt  <= APPLY_TC;
            step <= '0;
            if (n_lat != '0) dut_in <= tbl_in[0];
          end
        end
        S_APPLY: begin
          if (!cnt_tc) cnt <= cnt - CW'(1);
        end
        S_CHECK: begin
          if (step_fail) begin
            // err_count is zero only until the first failure, even when saturated
            if (err_count == 8'd0) first_fail <= step;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
          if (!last_step) begin
            step   <= step_inc;
            dut_in <= tbl_in[step_inc];
            cnt    <= APPLY_TC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_test_sequencer.sv
// Bench for io_test_sequencer: cycle-offset model of a run compared every cycle,
// plus directed runs with hand-computed run length and result values.
module tb_io_test_sequencer;

  localparam int W   = 32;
  localparam int RC  = 4;
  localparam int SC  = 8;
  localparam int SP  = SC + 1;
  localparam int DEP = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          ld_we;
  logic [3:0]    ld_addr;
  logic [63:0]   ld_in;
  logic [63:0]   ld_exp;
  logic [1:0]    ld_mask;
  logic          start;
  logic [4:0]    n_steps;
  logic [63:0]   dut_out;
  logic          dut_resetn;
  logic [63:0]   dut_in;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    err_count;
  logic [3:0]    first_fail;

  int n_cmp = 0;
  int n_bad = 0;

  io_test_sequencer #(
    .WIDTH(W), .NUM_IN(2), .NUM_OUT(2), .DEPTH(DEP),
    .RESET_CYCLES(RC), .STEP_CYCLES(SC)
  ) dut (
    .clock(clock), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_in(ld_in), .ld_exp(ld_exp), .ld_mask(ld_mask), .start(start),
    .n_steps(n_steps), .dut_out(dut_out), .dut_resetn(dut_resetn),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail)
  );

  always #5 clock = ~clock;

  // Computer stand-in: out_port0 echoes in_port0 two cycles late, out_port1 stays 0.
  logic [63:0] d1 = '0;
  logic [63:0] d2 = '0;
  always @(posedge clock) begin
    d1 <= dut_in;
    d2 <= d1;
  end
  assign dut_out = {32'h0, d2[31:0]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          mode = 0;   // 0 unknown, 1 post-reset idle, 2 run started
  int          k    = 0;   // cycles since the start edge
  int          mn   = 0;
  logic [31:0] m_in0 [DEP], m_in1 [DEP], m_exp0 [DEP], m_exp1 [DEP];
  logic [1:0]  m_mask [DEP];
  logic [31:0] s_in0 [DEP], s_in1 [DEP], s_exp0 [DEP], s_exp1 [DEP];
  logic [1:0]  s_mask [DEP];
  bit          m_busy;

  function automatic bit step_fails(input int s);
    return (s_mask[s][0] && (s_in0[s] != s_exp0[s])) ||
           (s_mask[s][1] && (s_exp1[s] != 32'h0));
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mode = 1;
    end else if (mode != 0) begin
      m_busy = (mode == 2) && (k <= RC + mn * SP);
      if (mode == 2 && k < 1000000) k++;
      if (ld_we && !m_busy) begin
        m_in0[ld_addr]  = ld_in[31:0];
        m_in1[ld_addr]  = ld_in[63:32];
        m_exp0[ld_addr] = ld_exp[31:0];
        m_exp1[ld_addr] = ld_exp[63:32];
        m_mask[ld_addr] = ld_mask;
      end
      if (start && !m_busy) begin
        for (int i = 0; i < DEP; i++) begin
          s_in0[i] = m_in0[i]; s_in1[i] = m_in1[i];
          s_exp0[i] = m_exp0[i]; s_exp1[i] = m_exp1[i]; s_mask[i] = m_mask[i];
        end
        mn   = (n_steps > 5'd16) ? DEP : int'(n_steps);
        mode = 2;
        k    = 1;
      end
    end
  end

  bit          e_busy, e_rn;
  logic [63:0] e_in;
  int          e_err, e_ff, e_s;

  always @(negedge clock) begin
    if (mode == 1) begin
      chk("idle_resetn", 64'(dut_resetn), 64'd1);
      chk("idle_dut_in", dut_in, 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_pass", 64'(pass), 64'd0);
      chk("idle_err", 64'(err_count), 64'd0);
      chk("idle_ff", 64'(first_fail), 64'd0);
    end else if (mode == 2) begin
      e_busy = (k <= RC + mn * SP);
      e_rn   = (k > RC);
      if (k <= RC) begin
        e_in = '0;
      end else if (e_busy) begin
        e_s  = (k - RC - 1) / SP;
        e_in = {s_in1[e_s], s_in0[e_s]};
      end else begin
        e_in = (mn > 0) ? {s_in1[mn-1], s_in0[mn-1]} : 64'd0;
      end
      e_err = 0;
      e_ff  = 0;
      for (int s = 0; s < mn; s++) begin
        if ((RC + (s + 1) * SP < k) && step_fails(s)) begin
          if (e_err == 0) e_ff = s;
          if (e_err < 255) e_err++;
        end
      end
      chk("run_resetn", 64'(dut_resetn), 64'(e_rn));
      chk("run_dut_in", dut_in, e_in);
      chk("run_busy", 64'(busy), 64'(e_busy));
      chk("run_done", 64'(done), 64'(!e_busy));
      chk("run_pass", 64'(pass), 64'(!e_busy && e_err == 0));
      chk("run_err", 64'(err_count), 64'(e_err));
      chk("run_ff", 64'(first_fail), 64'(e_ff));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] m);
    ld_we   = 1'b1;
    ld_addr = 4'(a);
    ld_in   = {i1, i0};
    ld_exp  = {e1, e0};
    ld_mask = m;
    cyc();
    ld_we = 1'b0;
  endtask

  task automatic run(input int n, output int cycles, output int lows);
    start   = 1'b1;
    n_steps = 5'(n);
    cyc();
    start  = 1'b0;
    cycles = 1;
    lows   = 0;
    while (!done && cycles < 2000) begin
      if (!dut_resetn) lows++;
      cyc();
      cycles++;
    end
  endtask

  int cyc_n, low_n;

  initial begin
    reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_in = '0; ld_exp = '0;
    ld_mask = '0; start = 1'b0; n_steps = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_resetn", 64'(dut_resetn), 64'd1);
    chk("rst_dut_in", dut_in, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);

    load(0, 32'd5, 32'hA0, 32'd5, 32'h0,    2'b01);
    load(1, 32'd6, 32'hA1, 32'd6, 32'hDEAD, 2'b01);
    load(2, 32'd7, 32'hA2, 32'd7, 32'h0,    2'b01);

    run(0, cyc_n, low_n);
    chk("n0_low_cycles", 64'(low_n), 64'd4);
    chk("n0_done_at", 64'(cyc_n), 64'd5);
    chk("n0_pass", 64'(pass), 64'd1);
    chk("n0_err", 64'(err_count), 64'd0);
    cyc();

    run(3, cyc_n, low_n);
    chk("pass3_done_at", 64'(cyc_n), 64'd32);
    chk("pass3_pass", 64'(pass), 64'd1);
    chk("pass3_err", 64'(err_count), 64'd0);
    chk("pass3_last_in", dut_in, {32'hA2, 32'd7});
    cyc();

    load(1, 32'd6, 32'hA1, 32'd9, 32'hDEAD, 2'b01);
    load(2, 32'd7, 32'hA2, 32'd0, 32'h0,    2'b01);
    run(3, cyc_n, low_n);
    chk("mis_done_at", 64'(cyc_n), 64'd32);
    chk("mis_err", 64'(err_count), 64'd2);
    chk("mis_ff", 64'(first_fail), 64'd1);
    chk("mis_pass", 64'(pass), 64'd0);
    cyc();

    // lockout: write and start while busy, then reset in APPLY
    start = 1'b1; n_steps = 5'd3;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    ld_we = 1'b1; ld_addr = 4'd1; ld_in = {32'hA1, 32'd6};
    ld_exp = {32'h0, 32'd6}; ld_mask = 2'b01;
    cyc();
    ld_we = 1'b0;
    repeat (2) cyc();
    start = 1'b1; n_steps = 5'd0;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    chk("lock_in_apply", dut_in, {32'hA0, 32'd5});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_resetn", 64'(dut_resetn), 64'd1);
    chk("mid_rst_dut_in", dut_in, 64'd0);
    cyc();

    run(3, cyc_n, low_n);
    chk("rerun_done_at", 64'(cyc_n), 64'd32);
    chk("rerun_err", 64'(err_count), 64'd2);
    chk("rerun_ff", 64'(first_fail), 64'd1);
    chk("rerun_pass", 64'(pass), 64'd0);
    cyc();

    // full table, n_steps clamped from 20 to 16
    for (int i = 3; i < DEP; i++) begin
      case (i)
        7:       load(i, 32'(i*3), 32'(i), 32'd1234,  32'h0, 2'b01);
        9:       load(i, 32'(i*3), 32'(i), 32'hBAD,   32'h7, 2'b00);
        12:      load(i, 32'(i*3), 32'(i), 32'd0,     32'h0, 2'b10);
        13:      load(i, 32'(i*3), 32'(i), 32'(i*3),  32'h5, 2'b10);
        default: load(i, 32'(i*3), 32'(i), 32'(i*3),  32'h0, 2'b01);
      endcase
    end
    run(20, cyc_n, low_n);
    chk("clamp_done_at", 64'(cyc_n), 64'd149);
    chk("clamp_err", 64'(err_count), 64'd4);
    chk("clamp_ff", 64'(first_fail), 64'd1);
    chk("clamp_last_in", dut_in, {32'd15, 32'd45});
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_test_sequencer.md
# io_test_sequencer

Parametrised, synthesizable stimulus-and-check harness for the single-cycle computer's I/O ports. It holds the device under test in reset for a programmable period, then walks a preloaded table of input-port vectors. After each vector has settled it compares the output ports against masked expected values, and it reports the pass/fail result, the error count and the first failing step. It sits between a board/bench controller and the computer's `in_port*`/`out_port*`/`resetn` pins, and it generalises fixed-value port drive with a single end-of-run display to N ports and M checked steps.

## Interface
Parameters:
- `WIDTH`, 32: bit width of each I/O port.
- `NUM_IN`, 2: number of driven input ports.
- `NUM_OUT`, 2: number of checked output ports.
- `DEPTH`, 16: step table entries; `AW = clog2(DEPTH)`.
- `RESET_CYCLES`, 4: cycles `dut_resetn` is held low at run start (≥1).
- `STEP_CYCLES`, 8: settle cycles per step before the check (≥1).

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ld_we`, in, 1: table write strobe.
- `ld_addr`, in, AW: table entry index.
- `ld_in`, in, NUM_IN*WIDTH: input vector; port i is bits [i*WIDTH +: WIDTH].
- `ld_exp`, in, NUM_OUT*WIDTH: expected output values, same packing as `ld_in`.
- `ld_mask`, in, NUM_OUT: per-port compare enable.
- `start`, in, 1: begin run (single-cycle pulse or level).
- `n_steps`, in, AW+1: steps to run, sampled with `start`; values > DEPTH are clamped to DEPTH.
- `dut_out`, in, NUM_OUT*WIDTH: computer output ports.
- `dut_resetn`, out, 1: active-low reset to the computer.
- `dut_in`, out, NUM_IN*WIDTH: driven input ports.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run finished; held until the next `start` or `reset`.
- `pass`, out, 1: valid when `done`; equals `err_count == 0`.
- `err_count`, out, 8: mismatching steps, saturates at 255.
- `first_fail`, out, AW: index of the first failing step; valid when `done && !pass`.

## Operation
- FSM states: IDLE, HOLD, APPLY, CHECK, DONE.
- IDLE or DONE, `start`=1: latch `n_steps`, clear `err_count`, `first_fail`, `done` and `pass`, then go to HOLD.
- HOLD: `dut_resetn`=0 and `dut_in`=0 for exactly RESET_CYCLES cycles. Then go to APPLY with step=0, or straight to DONE if `n_steps`=0, which is a pass.
- APPLY: `dut_in` = table[step].in, registered. Stay in APPLY for STEP_CYCLES cycles, then go to CHECK.
- CHECK: the step fails if, for any port j with mask[j]=1, `dut_out[j]` ≠ exp[j]. All-zero mask means the step cannot fail.
  - On a fail: `err_count` increments (saturating at 255).
  - On the first fail only: `first_fail` = step.
  - Next state: if step = n_steps−1, go to DONE; otherwise step+1 and back to APPLY.
- DONE: `done`=1, `pass` = (`err_count`==0), `dut_resetn`=1, `dut_in` holds the last vector.
- Table writes:
  - Accepted only when not `busy`; while `busy`, `ld_we` is ignored and the table is unchanged.
  - A write to an index ≥ DEPTH is ignored.
- `start` is ignored while `busy`.
- `reset` overrides everything, including mid-run: state goes to IDLE and all outputs take their reset values. Table contents are not cleared.

## Timing
- Reset values:
  - `dut_resetn`=1, `dut_in`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `first_fail`=0.
- `start` sampled at edge t, so in cycle t+1:
  - `busy`=1 and `dut_resetn`=0.
  - `dut_resetn` returns to 1 at t+1+RESET_CYCLES, in the same cycle that step 0's vector appears on `dut_in`.
- Each step occupies STEP_CYCLES+1 cycles: APPLY for STEP_CYCLES cycles, then CHECK for 1 cycle.
  - `dut_in` is stable for the whole step, including CHECK.
  - `dut_out` is sampled at the CHECK-cycle edge.
- Run length from `start` edge to `done`=1: RESET_CYCLES + n_steps·(STEP_CYCLES+1) + 1 cycles.
- `busy` falls in the same cycle `done` rises.
- CHECK updates to `err_count` and `first_fail` are visible in the following cycle.

## Test plan
- Reset/idle: assert `reset` 2 cycles. Required: `dut_resetn`=1, `dut_in`=0, `busy`=0, `done`=0, `err_count`=0.
- Reset hold length, RESET_CYCLES=4, `n_steps`=0: pulse `start`. Required: `dut_resetn` low for exactly 4 cycles, then `done`=1, `pass`=1, `err_count`=0.
- All pass, 3 steps, STEP_CYCLES=8, bench echoes `dut_out` = `dut_in` delayed by 2 cycles:
  - Table: in0 = 5/6/7, exp0 = 5/6/7, mask=01.
  - Required: `done` exactly 4+27+1=32 cycles after `start`, `pass`=1, `err_count`=0.
- Mismatch detection: same setup with step 1 exp0=9 and step 2 exp0=0. Required: `err_count`=2, `first_fail`=1, `pass`=0.
- Masking: step 1 exp1=0xDEAD, `dut_out[1]`=0, mask=01. Required: no error counted for step 1.
- Mid-run reset and lockout:
  - `ld_we` asserted while `busy`: table unchanged, confirmed by a later rerun.
  - `start` asserted while `busy`: ignored.
  - `reset` in an APPLY cycle: next cycle IDLE with reset values.
  - A fresh `start` then replays the original table with the same result.
